fifo_access_ctrl: RTL and testbench
===================================

# fifo_access_ctrl

Sequencing controller that shares one `fifo` instance between two byte producers (writer 0, writer 1) and one consumer (reader). It serializes all FIFO operations, grants by round-robin, drives the FIFO's multi-cycle push/pop handshake, and returns a one-cycle acknowledge to the granted requester. It sits directly in front of the `fifo` block; no requester touches the FIFO ports.

## Interface
- DATA_WIDTH, 8, byte width; matches the FIFO data width.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- wr_req[1:0]  in  2  per-writer request; held until `wr_ack` for that writer.
- wr_data0, wr_data1  in  DATA_WIDTH  writer payloads; stable while the corresponding request is high.
- wr_ack[1:0]  out  2  one-cycle done pulse per writer.
- rd_req  in  1  reader request; held until `rd_ack`.
- rd_data  out  DATA_WIDTH  popped byte; valid in the `rd_ack` cycle and held until the next read completes.
- rd_ack  out  1  one-cycle done pulse.
- drop  out  1  one-cycle pulse: the FIFO did not accept the issued operation.
- fifo_push, fifo_pop  out  1  one-cycle command pulses to the FIFO.
- fifo_data_in  out  DATA_WIDTH  registered payload to the FIFO.
- fifo_data_out  in  DATA_WIDTH  FIFO head byte.
- fifo_empty, fifo_full, fifo_busy  in  1  FIFO status.

## Operation
- **Eligibility.**
  - Writer i is eligible when `wr_req[i]` is high and `fifo_full` is 0.
  - The reader is eligible when `rd_req` is high and `fifo_empty` is 0.
- **Arbitration.**
  - Round-robin order is W0 → W1 → R → W0.
  - The pointer starts after the last granted requester.
  - The pointer advances only on grant.
- **State machine:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If `fifo_busy` is 0 and any requester is eligible, register the grant ID and go to ISSUE.
  - For a write, also register the payload into `fifo_data_in`.
- **ISSUE**
  - Assert `fifo_push` (write) or `fifo_pop` (read) for exactly one cycle.
  - For a read, capture `fifo_data_out` into an internal register in this cycle (head value before the pop).
  - Go to WAIT.
- **WAIT**
  - Keep `fifo_data_in` stable. The FIFO samples it one cycle after `fifo_push`.
  - First WAIT cycle with `fifo_busy` = 0: the operation was rejected. Pulse `drop`, send no ack, go to IDLE. The requester stays pending.
  - Otherwise stay in WAIT while `fifo_busy` = 1.
  - On the first cycle with `fifo_busy` = 0 after it was seen high, go to DONE.
- **DONE**
  - Pulse `wr_ack[id]` or `rd_ack` for one cycle.
  - For a read, update `rd_data` from the captured byte.
  - Go to IDLE.
- A requester that drops its request before grant is withdrawn. Request level after grant is ignored until DONE.
- Only one operation is in flight, so the FIFO never sees push and pop together.

## Timing
- **Reset values.**
  - State IDLE; round-robin pointer set so W0 has first priority.
  - All outputs 0: `fifo_push`, `fifo_pop`, `fifo_data_in`, `rd_data`, both acks, `drop`.
  - Reset mid-operation abandons it: no ack, no drop.
- **Write latency** (FIFO busy for 2 cycles), request first seen in IDLE at cycle t:
  - ISSUE at t+1; WAIT t+2..t+4 (`fifo_busy` high t+2, t+3; low t+4); DONE/`wr_ack` at t+5.
- **Read latency** (busy for 1 cycle):
  - ISSUE t+1, WAIT t+2..t+3, `rd_ack` at t+4.
- **Back-to-back:** a held request after DONE is re-evaluated in the IDLE cycle that follows. Minimum spacing between grants is one IDLE cycle.
- **Full/empty boundaries:**
  - `fifo_full` = 1 blocks only writers. `fifo_empty` = 1 blocks only the reader.
  - Both are sampled only in IDLE.
- **`fifo_busy` high in IDLE** (e.g. after reset release): no grant; the block waits.

## Structure
- **Package `fifo_ctrl_pkg`:**
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3;
  - requester IDs: W0=2'd0, W1=2'd1, RD=2'd2.
- **Sub-module `rr_arbiter3`:**
  - 3-bit eligible vector in; one-hot grant plus encoded ID out;
  - pointer update on a `grant_en` strobe;
  - reset to W0 priority.
- **Top level:** FSM, payload/read-data registers, command pulse generation.

## Test plan
- Reset, then W0 requests 8'hA5 with the FIFO empty.
  - `fifo_push` at t+1; `fifo_data_in` = A5 held through t+3; `wr_ack[0]` only at t+5.
  - FIFO `data_count` becomes 1.
- W0, W1 and R all request continuously with the FIFO non-empty and non-full: grants in order W0, W1, R, W0, …; exactly one ack per completed operation.
- Push 8'h3C, then R requests: `rd_ack` arrives 4 cycles after IDLE sampling, `rd_data` = 3C, `fifo_empty` returns to 1.
- FIFO full with W1 and R requesting: W1 is never granted; R is granted. After `rd_ack`, W1 is granted on the next IDLE.
- Tie `fifo_busy` low during WAIT (model a FIFO reject): `drop` pulses once, no ack, and the same requester is regranted later.
- Assert `reset` during WAIT of a write: all outputs 0 the same cycle; no `wr_ack`; after release W0 has first priority.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared encodings for the FIFO access controller: FSM states, requester IDs
// and the round-robin successor function.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ID_W0 = 2'd0;
  localparam logic [1:0] ID_W1 = 2'd1;
  localparam logic [1:0] ID_RD = 2'd2;

  // Order is W0 -> W1 -> RD -> W0.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == ID_RD) ? ID_W0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_access_ctrl_rr_arbiter3.sv
// Three-way round-robin arbiter: combinational grant from the eligible vector,
// priority pointer moves past the winner only when i_grant_en is strobed.
module rr_arbiter3
  import fifo_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_elig,
  input  logic       i_grant_en,
  output logic [2:0] o_grant,
  output logic [1:0] o_grant_id
);

  logic [1:0] r_last;
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic [3:0] w_elig;

  always_comb begin
    w_elig     = {1'b0, i_elig};
    w_c0       = rr_next(r_last);
    w_c1       = rr_next(w_c0);
    w_c2       = rr_next(w_c1);
    o_grant_id = w_c0;
    o_grant    = 3'b000;
    if (w_elig[w_c0]) begin
      o_grant_id = w_c0;
    end else if (w_elig[w_c1]) begin
      o_grant_id = w_c1;
    end else if (w_elig[w_c2]) begin
      o_grant_id = w_c2;
    end
    if (|i_elig) begin
      o_grant = 3'b001 << o_grant_id;
    end
  end

  // Resetting to RD as "last granted" gives W0 first priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= ID_RD;
    end else if (i_grant_en && (|i_elig)) begin
      r_last <= o_grant_id;
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Serializes two byte writers and one reader onto a shared FIFO with a
// round-robin grant; one operation in flight, ack on completion, drop on reject.
module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [1:0]            i_wr_req,
  input  logic [DATA_WIDTH-1:0] i_wr_data0,
  input  logic [DATA_WIDTH-1:0] i_wr_data1,
  output logic [1:0]            o_wr_ack,
  input  logic                  i_rd_req,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_ack,
  output logic                  o_drop,
  output logic                  o_fifo_push,
  output logic                  o_fifo_pop,
  output logic [DATA_WIDTH-1:0] o_fifo_data_in,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_out,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_full,
  input  logic                  i_fifo_busy
);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_id;
  logic [1:0]            w_grant_id;
  logic [2:0]            w_elig;
  logic [2:0]            w_grant;
  logic                  w_grant_en;
  logic                  w_is_rd;
  logic                  r_seen_busy;
  logic                  r_drop;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic [DATA_WIDTH-1:0] r_rd_cap;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_wr_ack;
  logic                  w_rd_ack;
  logic                  w_reject;
  logic                  w_complete;

  // Full gates only writers, empty gates only the reader.
  assign w_elig     = {i_rd_req & ~i_fifo_empty, i_wr_req & {2{~i_fifo_full}}};
  assign w_grant_en = (r_state == ST_IDLE) && !i_fifo_busy && (|w_grant);
  assign w_is_rd    = (r_id == ID_RD);

  rr_arbiter3 u_arb (
    .i_clk      (i_clock),
    .i_rst      (i_reset),
    .i_elig     (w_elig),
    .i_grant_en (w_grant_en),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_wr_ack   = 2'b00;
    w_rd_ack   = 1'b0;
    w_reject   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_en) begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_push = !w_is_rd;
        w_pop  = w_is_rd;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        // A FIFO that never raises busy has refused the command.
        if (!i_fifo_busy) begin
          if (r_seen_busy) begin
            w_complete = 1'b1;
            w_next     = ST_DONE;
          end else begin
            w_reject = 1'b1;
            w_next   = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (w_is_rd) begin
          w_rd_ack = 1'b1;
        end else if (r_id == ID_W1) begin
          w_wr_ack = 2'b10;
        end else begin
          w_wr_ack = 2'b01;
        end
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_id        <= ID_W0;
      r_data_in   <= '0;
      r_rd_cap    <= '0;
      r_rd_data   <= '0;
      r_seen_busy <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_reject;
      if (w_grant_en) begin
        r_id <= w_grant_id;
        if (w_grant[0] || w_grant[1]) begin
          r_data_in <= w_grant[1] ? i_wr_data1 : i_wr_data0;
        end
      end
      // Head byte is sampled in the pop cycle, before the FIFO advances.
      if (r_state == ST_ISSUE) begin
        r_seen_busy <= 1'b0;
        if (w_is_rd) begin
          r_rd_cap <= i_fifo_data_out;
        end
      end else if ((r_state == ST_WAIT) && i_fifo_busy) begin
        r_seen_busy <= 1'b1;
      end
      if (w_complete && w_is_rd) begin
        r_rd_data <= r_rd_cap;
      end
    end
  end

  assign o_fifo_push    = w_push;
  assign o_fifo_pop     = w_pop;
  assign o_fifo_data_in = r_data_in;
  assign o_wr_ack       = w_wr_ack;
  assign o_rd_ack       = w_rd_ack;
  assign o_rd_data      = r_rd_data;
  assign o_drop         = r_drop;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl with a small 4-deep FIFO model behind it.
module tb_fifo_access_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] wr_req;
  logic [7:0] wr_data0;
  logic [7:0] wr_data1;
  logic [1:0] o_wr_ack;
  logic       rd_req;
  logic [7:0] o_rd_data;
  logic       o_rd_ack;
  logic       o_drop;
  logic       o_fifo_push;
  logic       o_fifo_pop;
  logic [7:0] o_fifo_data_in;
  logic [7:0] fifo_data_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_busy;

  int total;
  int bad;

  // FIFO model: push -> busy 2 cycles, data sampled one cycle after push;
  // pop -> busy 1 cycle. m_reject makes it ignore commands entirely.
  logic [7:0] m_mem [4];
  logic [1:0] m_rp;
  logic [1:0] m_wp;
  int         m_cnt;
  int         m_busy_cnt;
  logic       m_wr_pend;
  logic       m_reject;
  logic       m_force_busy;

  assign fifo_empty    = (m_cnt == 0);
  assign fifo_full     = (m_cnt == 4);
  assign fifo_busy     = (m_busy_cnt != 0) || m_force_busy;
  assign fifo_data_out = m_mem[m_rp];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rp       <= 2'd0;
      m_wp       <= 2'd0;
      m_cnt      <= 0;
      m_busy_cnt <= 0;
      m_wr_pend  <= 1'b0;
    end else begin
      if (m_busy_cnt > 0) m_busy_cnt <= m_busy_cnt - 1;
      if (m_wr_pend) begin
        m_mem[m_wp] <= o_fifo_data_in;
        m_wp        <= m_wp + 2'd1;
        m_cnt       <= m_cnt + 1;
        m_wr_pend   <= 1'b0;
      end
      if (o_fifo_push && !m_reject) begin
        m_busy_cnt <= 2;
        m_wr_pend  <= 1'b1;
      end
      if (o_fifo_pop && !m_reject) begin
        m_busy_cnt <= 1;
        m_rp       <= m_rp + 2'd1;
        m_cnt      <= m_cnt - 1;
      end
    end
  end

  fifo_access_ctrl #(.DATA_WIDTH(8)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_wr_req        (wr_req),
    .i_wr_data0      (wr_data0),
    .i_wr_data1      (wr_data1),
    .o_wr_ack        (o_wr_ack),
    .i_rd_req        (rd_req),
    .o_rd_data       (o_rd_data),
    .o_rd_ack        (o_rd_ack),
    .o_drop          (o_drop),
    .o_fifo_push     (o_fifo_push),
    .o_fifo_pop      (o_fifo_pop),
    .o_fifo_data_in  (o_fifo_data_in),
    .i_fifo_data_out (fifo_data_out),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_full     (fifo_full),
    .i_fifo_busy     (fifo_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({o_fifo_push, o_fifo_pop, o_wr_ack, o_rd_ack, o_drop} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000", {o_fifo_push, o_fifo_pop, o_wr_ack, o_rd_ack, o_drop});
    end
    total++;
    if (o_fifo_data_in !== 8'h00) begin
      bad++;
      $display("FAIL reset_data_in got=%h want=00", o_fifo_data_in);
    end
    total++;
    if (o_rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_data got=%h want=00", o_rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_busy_idle();
    logic seen;
    seen = 1'b0;
    m_force_busy = 1'b1;
    wr_data0 = 8'hEE;
    wr_req = 2'b01;
    repeat (4) begin
      tick();
      if (o_fifo_push) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle_grant got=%b want=0", seen);
    end
    wr_req = 2'b00;
    m_force_busy = 1'b0;
    tick();
  endtask

  task automatic test_write_w0();
    logic [1:0] exp_ack;
    wr_data0 = 8'hA5;
    wr_req = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_ack = (k == 5) ? 2'b01 : 2'b00;
      total++;
      if (o_fifo_push !== (k == 1)) begin
        bad++;
        $display("FAIL write_push k=%0d got=%b want=%b", k, o_fifo_push, (k == 1));
      end
      total++;
      if (o_wr_ack !== exp_ack) begin
        bad++;
        $display("FAIL write_ack k=%0d got=%b want=%b", k, o_wr_ack, exp_ack);
      end
      if (k <= 3) begin
        total++;
        if (o_fifo_data_in !== 8'hA5) begin
          bad++;
          $display("FAIL write_data_in k=%0d got=%h want=a5", k, o_fifo_data_in);
        end
      end
      if (k == 5) wr_req = 2'b00;
    end
    total++;
    if (m_cnt != 1 || m_mem[0] !== 8'hA5) begin
      bad++;
      $display("FAIL write_fifo_count got=%0d/%h want=1/a5", m_cnt, m_mem[0]);
    end
  endtask

  task automatic test_read();
    rd_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (o_fifo_pop !== (k == 1)) begin
        bad++;
        $display("FAIL read_pop k=%0d got=%b want=%b", k, o_fifo_pop, (k == 1));
      end
      total++;
      if (o_rd_ack !== (k == 4)) begin
        bad++;
        $display("FAIL read_ack k=%0d got=%b want=%b", k, o_rd_ack, (k == 4));
      end
      if (k >= 4) begin
        total++;
        if (o_rd_data !== 8'hA5) begin
          bad++;
          $display("FAIL read_data k=%0d got=%h want=a5", k, o_rd_data);
        end
      end
      if (k == 4) rd_req = 1'b0;
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL read_empty got=%b want=1", fifo_empty);
    end
  endtask

  task automatic test_push_read_3c();
    logic got;
    got = 1'b0;
    wr_data0 = 8'h3C;
    wr_req = 2'b01;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[0]) got = 1'b1;
    end
    wr_req = 2'b00;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL push3c_ack got=0 want=1");
    end
    tick();
    rd_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (o_rd_ack !== (k == 4)) begin
        bad++;
        $display("FAIL read3c_ack k=%0d got=%b want=%b", k, o_rd_ack, (k == 4));
      end
      if (k == 4) begin
        total++;
        if (o_rd_data !== 8'h3C) begin
          bad++;
          $display("FAIL read3c_data got=%h want=3c", o_rd_data);
        end
        rd_req = 1'b0;
      end
    end
    total++;
    if (fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL read3c_empty got=%b want=1", fifo_empty);
    end
  endtask

  task automatic test_round_robin();
    int         exp_id [6];
    logic [7:0] exp_rd [2];
    int         n;
    int         nr;
    int         id;
    logic       got;
    exp_id = '{1, 2, 0, 1, 2, 0};
    exp_rd = '{8'h11, 8'h30};
    got = 1'b0;
    wr_data0 = 8'h11;
    wr_req = 2'b01;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[0]) got = 1'b1;
    end
    wr_req = 2'b00;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rr_preload_ack got=0 want=1");
    end
    tick();
    wr_data0 = 8'h20;
    wr_data1 = 8'h30;
    wr_req = 2'b11;
    rd_req = 1'b1;
    n = 0;
    nr = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      tick();
      total++;
      if (o_fifo_push && o_fifo_pop) begin
        bad++;
        $display("FAIL rr_push_pop_overlap got=11 want=not both");
      end
      if (|{o_wr_ack, o_rd_ack}) begin
        id = o_rd_ack ? 2 : (o_wr_ack[1] ? 1 : 0);
        total++;
        if ($countones({o_wr_ack, o_rd_ack}) != 1 || id != exp_id[n]) begin
          bad++;
          $display("FAIL rr_grant_order n=%0d got=%b want_id=%0d", n, {o_wr_ack, o_rd_ack}, exp_id[n]);
        end
        if (o_rd_ack && nr < 2) begin
          total++;
          if (o_rd_data !== exp_rd[nr]) begin
            bad++;
            $display("FAIL rr_rd_data nr=%0d got=%h want=%h", nr, o_rd_data, exp_rd[nr]);
          end
          nr++;
        end
        n++;
        if (n == 6) begin
          wr_req = 2'b00;
          rd_req = 1'b0;
        end
      end
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL rr_ack_count got=%0d want=6", n);
    end
    wr_req = 2'b00;
    rd_req = 1'b0;
    tick();
    total++;
    if (m_cnt != 3) begin
      bad++;
      $display("FAIL rr_fifo_count got=%0d want=3", m_cnt);
    end
  endtask

  task automatic test_full_boundary();
    logic got;
    logic early;
    got = 1'b0;
    wr_data0 = 8'h44;
    wr_req = 2'b01;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[0]) got = 1'b1;
    end
    wr_req = 2'b00;
    tick();
    total++;
    if (fifo_full !== 1'b1) begin
      bad++;
      $display("FAIL full_reached got=%b want=1", fifo_full);
    end
    wr_data1 = 8'h30;
    wr_req = 2'b10;
    rd_req = 1'b1;
    got = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (o_fifo_push || o_wr_ack[1]) early = 1'b1;
      if (o_rd_ack) begin
        got = 1'b1;
        total++;
        if (o_rd_data !== 8'h20) begin
          bad++;
          $display("FAIL full_rd_data got=%h want=20", o_rd_data);
        end
        rd_req = 1'b0;
      end
    end
    rd_req = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL full_rd_ack got=0 want=1");
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL full_writer_blocked got=%b want=0", early);
    end
    tick();
    total++;
    if (o_fifo_push !== 1'b0) begin
      bad++;
      $display("FAIL full_idle_push got=%b want=0", o_fifo_push);
    end
    tick();
    total++;
    if (o_fifo_push !== 1'b1 || o_fifo_data_in !== 8'h30) begin
      bad++;
      $display("FAIL full_w1_grant got=%b/%h want=1/30", o_fifo_push, o_fifo_data_in);
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[1]) got = 1'b1;
    end
    wr_req = 2'b00;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL full_w1_ack got=0 want=1");
    end
    tick();
    total++;
    if (m_cnt != 4) begin
      bad++;
      $display("FAIL full_fifo_count got=%0d want=4", m_cnt);
    end
  endtask

  task automatic test_reject();
    int   drops;
    logic early_ack;
    logic got;
    drops = 0;
    early_ack = 1'b0;
    got = 1'b0;
    m_reject = 1'b1;
    rd_req = 1'b1;
    tick();
    drops += int'(o_drop);
    total++;
    if (o_fifo_pop !== 1'b1) begin
      bad++;
      $display("FAIL reject_first_pop got=%b want=1", o_fifo_pop);
    end
    tick();
    drops += int'(o_drop);
    if (o_rd_ack) early_ack = 1'b1;
    tick();
    drops += int'(o_drop);
    if (o_rd_ack) early_ack = 1'b1;
    total++;
    if (o_drop !== 1'b1) begin
      bad++;
      $display("FAIL reject_drop got=%b want=1", o_drop);
    end
    m_reject = 1'b0;
    tick();
    drops += int'(o_drop);
    total++;
    if (o_fifo_pop !== 1'b1) begin
      bad++;
      $display("FAIL reject_regrant got=%b want=1", o_fifo_pop);
    end
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      drops += int'(o_drop);
      if (o_rd_ack) begin
        got = 1'b1;
        total++;
        if (o_rd_data !== 8'h30) begin
          bad++;
          $display("FAIL reject_rd_data got=%h want=30", o_rd_data);
        end
        rd_req = 1'b0;
      end
    end
    rd_req = 1'b0;
    total++;
    if (!got || early_ack) begin
      bad++;
      $display("FAIL reject_ack got=%b early=%b want=1/0", got, early_ack);
    end
    total++;
    if (drops != 1) begin
      bad++;
      $display("FAIL reject_drop_count got=%0d want=1", drops);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic ack_seen;
    logic got;
    ack_seen = 1'b0;
    wr_data0 = 8'h77;
    wr_req = 2'b01;
    tick();
    total++;
    if (o_fifo_push !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_push got=%b want=1", o_fifo_push);
    end
    tick();
    total++;
    if (o_fifo_data_in !== 8'h77) begin
      bad++;
      $display("FAIL rstmid_data_in got=%h want=77", o_fifo_data_in);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({o_fifo_push, o_fifo_pop, o_wr_ack, o_rd_ack, o_drop} !== 5'b0 ||
        o_fifo_data_in !== 8'h00 || o_rd_data !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b/%h/%h want=00000/00/00",
               {o_fifo_push, o_fifo_pop, o_wr_ack, o_rd_ack, o_drop}, o_fifo_data_in, o_rd_data);
    end
    wr_req = 2'b00;
    repeat (2) begin
      tick();
      if (|o_wr_ack || o_drop) ack_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      if (|o_wr_ack || o_drop) ack_seen = 1'b1;
    end
    total++;
    if (ack_seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_ack got=%b want=0", ack_seen);
    end
    wr_data0 = 8'h5A;
    wr_data1 = 8'hB6;
    wr_req = 2'b11;
    tick();
    total++;
    if (o_fifo_push !== 1'b1 || o_fifo_data_in !== 8'h5A) begin
      bad++;
      $display("FAIL rstmid_w0_first got=%b/%h want=1/5a", o_fifo_push, o_fifo_data_in);
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[0]) got = 1'b1;
    end
    wr_req = 2'b10;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rstmid_w0_ack got=0 want=1");
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (o_wr_ack[1]) got = 1'b1;
    end
    wr_req = 2'b00;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rstmid_w1_ack got=0 want=1");
    end
    tick();
    total++;
    if (m_cnt != 2 || m_mem[0] !== 8'h5A || m_mem[1] !== 8'hB6) begin
      bad++;
      $display("FAIL rstmid_fifo got=%0d/%h/%h want=2/5a/b6", m_cnt, m_mem[0], m_mem[1]);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    wr_req = 2'b00;
    wr_data0 = 8'h00;
    wr_data1 = 8'h00;
    rd_req = 1'b0;
    m_reject = 1'b0;
    m_force_busy = 1'b0;
    test_reset();
    test_busy_idle();
    test_write_w0();
    test_read();
    test_push_read_3c();
    test_round_robin();
    test_full_boundary();
    test_reject();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
